quad_angle_tracker: RTL and testbench

Parametrised quadrature angle tracker for the optical encoder on the motor shaft. It synchronises the raw OPTOA/OPTOB channels and decodes the Gray-code sequence in x4 or x1 mode. It maintains a wrap-around position count over one revolution, plus a signed revolution count, a direction flag and a sticky illegal-transition error. It replaces the latch-based angle counter and feeds the PWM position controller and the SPI readback registers.

---
 rtl/quad_angle_tracker_if.sv | 29 ++
 rtl/quad_angle_tracker.sv | 149 ++++++++++++++
 tb/tb_quad_angle_tracker.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_angle_tracker_if.sv
// Bus bundle for quad_angle_tracker: control strobes, raw opto inputs and
// the registered position/revolution/status outputs.
interface quad_angle_tracker_if #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned REV_WIDTH = 8
);
    logic                 PM;
    logic                 ZERO;
    logic                 ERR_CLR;
    logic                 OPTOA;
    logic                 OPTOB;
    logic [WIDTH-1:0]     Q;
    logic [REV_WIDTH-1:0] REV;
    logic                 DIR;
    logic                 STEP;
    logic                 ERR;

    // Controller side: drives strobes and encoder pins, reads results
    modport master (
        output PM, ZERO, ERR_CLR, OPTOA, OPTOB,
        input  Q, REV, DIR, STEP, ERR
    );

    // Tracker side
    modport slave (
        input  PM, ZERO, ERR_CLR, OPTOA, OPTOB,
        output Q, REV, DIR, STEP, ERR
    );
endinterface

// File: rtl/quad_angle_tracker.sv
// Quadrature angle tracker: synchronises OPTOA/OPTOB, decodes the Gray
// sequence (x4 or x1), keeps a wrap-around position Q, a signed revolution
// count REV, a direction flag, a one-cycle STEP pulse and a sticky ERR flag.
// Optional glitch filter on each synchronised channel: QUAD_GLITCH_FILTER_EN.
module quad_angle_tracker #(
    parameter int unsigned WIDTH          = 12,
    parameter int unsigned COUNTS_PER_REV = 1006,
    parameter int unsigned REV_WIDTH      = 8,
    parameter int unsigned MODE           = 4,
    parameter int unsigned SYNC_STAGES    = 2
`ifdef QUAD_GLITCH_FILTER_EN
    ,
    parameter int unsigned FILTER_CYCLES  = 4
`endif
) (
    input logic                 CLK,
    input logic                 RESET,
    quad_angle_tracker_if.slave qbus
);

    localparam logic [WIDTH-1:0] QMAX = WIDTH'(COUNTS_PER_REV - 1);

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_CW,
        DEC_CCW,
        DEC_ILLEGAL
    } dec_t;

    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic [1:0]             w_sync_ab;
    logic [1:0]             w_src_ab;
    logic [1:0]             r_cur;
    logic [1:0]             r_prev;
    dec_t                   w_dec;
    logic                   w_count;
    logic [WIDTH-1:0]       r_q;
    logic [REV_WIDTH-1:0]   r_rev;
    logic                   r_dir;
    logic                   r_step;
    logic                   r_err;

    // Metastability shift chains for the asynchronous opto channels
    always_ff @(posedge CLK) begin
        r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], qbus.OPTOA};
        r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], qbus.OPTOB};
    end

    assign w_sync_ab = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};

`ifdef QUAD_GLITCH_FILTER_EN
    localparam int unsigned FCW = $clog2(FILTER_CYCLES + 1);

    logic [1:0]     r_filt;
    logic [FCW-1:0] r_fcnt [2];

    // Per-channel stability filter: a new level must persist FILTER_CYCLES clocks
    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (RESET) begin
                r_fcnt[i] <= '0;
                r_filt[i] <= w_sync_ab[i];
            end else if (w_sync_ab[i] != r_filt[i]) begin
                if (r_fcnt[i] == FCW'(FILTER_CYCLES - 1)) begin
                    r_filt[i] <= w_sync_ab[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + FCW'(1);
                end
            end else begin
                r_fcnt[i] <= '0;
            end
        end
    end

    assign w_src_ab = r_filt;
`else
    assign w_src_ab = w_sync_ab;
`endif

    // Classify the prev->cur transition of the Gray pair (AB)
    always_comb begin
        w_dec = DEC_IDLE;
        case ({r_prev, r_cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_dec = DEC_CW;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: w_dec = DEC_CCW;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: w_dec = DEC_ILLEGAL;
            default:                                w_dec = DEC_IDLE;
        endcase
    end

    // x1 mode only counts the steps that land on AB=00
    assign w_count = ((w_dec == DEC_CW) || (w_dec == DEC_CCW)) &&
                     ((MODE != 1) || (r_cur == 2'b00));

    // Decoder registers, position/revolution counters and status flags
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cur  <= w_src_ab;
            r_prev <= w_src_ab;
            r_q    <= '0;
            r_rev  <= '0;
            r_dir  <= 1'b1;
            r_step <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_cur  <= w_src_ab;
            r_prev <= r_cur;
            r_step <= 1'b0;

            if (w_dec == DEC_ILLEGAL) begin
                r_err <= 1'b1;
            end else if (qbus.ERR_CLR) begin
                r_err <= 1'b0;
            end

            if (qbus.ZERO) begin
                r_q   <= '0;
                r_rev <= '0;
            end else if (qbus.PM && w_count) begin
                r_step <= 1'b1;
                r_dir  <= (w_dec == DEC_CW);
                if (w_dec == DEC_CW) begin
                    if (r_q == QMAX) begin
                        r_q   <= '0;
                        r_rev <= r_rev + REV_WIDTH'(1);
                    end else begin
                        r_q <= r_q + WIDTH'(1);
                    end
                end else begin
                    if (r_q == '0) begin
                        r_q   <= QMAX;
                        r_rev <= r_rev - REV_WIDTH'(1);
                    end else begin
                        r_q <= r_q - WIDTH'(1);
                    end
                end
            end
        end
    end

    assign qbus.Q    = r_q;
    assign qbus.REV  = r_rev;
    assign qbus.DIR  = r_dir;
    assign qbus.STEP = r_step;
    assign qbus.ERR  = r_err;

endmodule

// File: tb/tb_quad_angle_tracker.sv
// Scoreboard bench for quad_angle_tracker: an x4 and an x1 instance share
// the same pin stimulus; a position model based on a signed total count
// predicts every STEP and the settled Q/REV/DIR/ERR values.
`timescale 1ns/1ps
module tb_quad_angle_tracker;
    localparam int CPR = 1006;
    localparam int W   = 12;
    localparam int RW  = 8;
`ifdef QUAD_GLITCH_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    typedef struct packed {
        logic [W-1:0]  q;
        logic [RW-1:0] rev;
        logic          dir;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quad_angle_tracker_if #(.WIDTH(W), .REV_WIDTH(RW)) bus4 ();
    quad_angle_tracker_if #(.WIDTH(W), .REV_WIDTH(RW)) bus1 ();

    assign bus1.PM      = bus4.PM;
    assign bus1.ZERO    = bus4.ZERO;
    assign bus1.ERR_CLR = bus4.ERR_CLR;
    assign bus1.OPTOA   = bus4.OPTOA;
    assign bus1.OPTOB   = bus4.OPTOB;

    quad_angle_tracker #(.WIDTH(W), .COUNTS_PER_REV(CPR), .REV_WIDTH(RW),
                         .MODE(4), .SYNC_STAGES(2))
        dut4 (.CLK(clk), .RESET(rst), .qbus(bus4));

    quad_angle_tracker #(.WIDTH(W), .COUNTS_PER_REV(CPR), .REV_WIDTH(RW),
                         .MODE(1), .SYNC_STAGES(2))
        dut1 (.CLK(clk), .RESET(rst), .qbus(bus1));

    int   errors = 0;
    int   checks = 0;
    int   steps1 = 0;
    exp_t q4[$];
    exp_t q1[$];

    // reference model state
    int         tot4, tot1;
    bit         dir4, dir1, m_err;
    logic [1:0] cur_ab;

    function automatic int phase(logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gray(int p);
        int m;
        m = ((p % 4) + 4) % 4;
        case (m)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic exp_t model_out(int tot, bit d);
        int   q, r;
        exp_t e;
        q = tot % CPR;
        if (q < 0) q += CPR;
        r = (tot - q) / CPR;
        e.q   = W'(q);
        e.rev = RW'(r);
        e.dir = d;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_state(string tag);
        exp_t e4, e1;
        e4 = model_out(tot4, dir4);
        e1 = model_out(tot1, dir1);
        @(negedge clk);
        chk({tag, "_q4"},   32'(bus4.Q),   32'(e4.q));
        chk({tag, "_rev4"}, 32'(bus4.REV), 32'(e4.rev));
        chk({tag, "_dir4"}, 32'(bus4.DIR), 32'(e4.dir));
        chk({tag, "_err4"}, 32'(bus4.ERR), 32'(m_err));
        chk({tag, "_q1"},   32'(bus1.Q),   32'(e1.q));
        chk({tag, "_rev1"}, 32'(bus1.REV), 32'(e1.rev));
        chk({tag, "_dir1"}, 32'(bus1.DIR), 32'(e1.dir));
        chk({tag, "_err1"}, 32'(bus1.ERR), 32'(m_err));
    endtask

    // Predict the effect of moving the pins to ab, then drive it; ZERO and
    // ERR_CLR (if requested) are presented on the edge where the step decodes.
    task automatic issue(logic [1:0] ab, bit pm, bit zero, bit clr);
        int d;
        bit cnt4, cnt1;
        d    = (phase(ab) - phase(cur_ab) + 4) % 4;
        cnt4 = pm && (d == 1 || d == 3) && !zero;
        cnt1 = cnt4 && (ab == 2'b00);
        if (zero) begin
            tot4 = 0;
            tot1 = 0;
        end
        if (cnt4) begin
            tot4 += (d == 1) ? 1 : -1;
            dir4 = (d == 1);
            q4.push_back(model_out(tot4, dir4));
        end
        if (cnt1) begin
            tot1 += (d == 1) ? 1 : -1;
            dir1 = (d == 1);
            q1.push_back(model_out(tot1, dir1));
        end
        if (d == 2) m_err = 1'b1;
        else if (clr) m_err = 1'b0;

        @(negedge clk);
        bus4.OPTOA = ab[1];
        bus4.OPTOB = ab[0];
        bus4.PM    = pm;
        cur_ab     = ab;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        bus4.ZERO    = zero;
        bus4.ERR_CLR = clr;
        @(negedge clk);
        bus4.ZERO    = 1'b0;
        bus4.ERR_CLR = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One CW step with the exact update edge checked on the x4 instance
    task automatic lat_step(string tag);
        exp_t e;
        tot4++;
        dir4 = 1'b1;
        e = model_out(tot4, dir4);
        q4.push_back(e);
        @(negedge clk);
        cur_ab     = gray(phase(cur_ab) + 1);
        bus4.OPTOA = cur_ab[1];
        bus4.OPTOB = cur_ab[0];
        if (cur_ab == 2'b00) begin
            tot1++;
            dir1 = 1'b1;
            q1.push_back(model_out(tot1, dir1));
        end
        repeat (LAT) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_early_q"}, 32'(bus4.Q), 32'(model_out(tot4 - 1, 1'b1).q));
        @(posedge clk);
        #1;
        chk({tag, "_ontime_q"},    32'(bus4.Q),    32'(e.q));
        chk({tag, "_ontime_step"}, 32'(bus4.STEP), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(logic [1:0] ab);
        @(negedge clk);
        rst        = 1'b1;
        bus4.OPTOA = ab[1];
        bus4.OPTOB = ab[0];
        cur_ab     = ab;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        tot4 = 0;
        tot1 = 0;
        dir4 = 1'b1;
        dir1 = 1'b1;
        m_err = 1'b0;
    endtask

    // Monitor: every STEP pulse must match the oldest predicted step
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                if (bus4.STEP === 1'b1) begin
                    if (q4.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL step4_unexpected actual=1 required=0 q=%0d", bus4.Q);
                    end else begin
                        e = q4.pop_front();
                        chk("step4_q",   32'(bus4.Q),   32'(e.q));
                        chk("step4_rev", 32'(bus4.REV), 32'(e.rev));
                        chk("step4_dir", 32'(bus4.DIR), 32'(e.dir));
                    end
                end
                if (bus1.STEP === 1'b1) begin
                    steps1++;
                    if (q1.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL step1_unexpected actual=1 required=0 q=%0d", bus1.Q);
                    end else begin
                        e = q1.pop_front();
                        chk("step1_q",   32'(bus1.Q),   32'(e.q));
                        chk("step1_rev", 32'(bus1.REV), 32'(e.rev));
                        chk("step1_dir", 32'(bus1.DIR), 32'(e.dir));
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base1;
        int r;
        rst          = 1'b1;
        bus4.PM      = 1'b1;
        bus4.ZERO    = 1'b0;
        bus4.ERR_CLR = 1'b0;
        bus4.OPTOA   = 1'b0;
        bus4.OPTOB   = 1'b0;
        cur_ab       = 2'b00;

        // reset state
        do_reset(2'b00);
        @(negedge clk);
        chk("rst_q",    32'(bus4.Q),    32'd0);
        chk("rst_rev",  32'(bus4.REV),  32'd0);
        chk("rst_dir",  32'(bus4.DIR),  32'd1);
        chk("rst_step", 32'(bus4.STEP), 32'd0);
        chk("rst_err",  32'(bus4.ERR),  32'd0);

        // first step latency, 00->10
        lat_step("lat");
        check_state("after_lat");

        // re-home, then CW wrap over one revolution
        issue(cur_ab, 1'b1, 1'b1, 1'b0);
        check_state("zero");
        for (int i = 0; i < CPR - 1; i++)
            issue(gray(phase(cur_ab) + 1), 1'b1, 1'b0, 1'b0);
        check_state("pre_wrap");
        issue(gray(phase(cur_ab) + 1), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("wrap_q",   32'(bus4.Q),   32'd0);
        chk("wrap_rev", 32'(bus4.REV), 32'd1);
        issue(gray(phase(cur_ab) - 1), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("unwrap_q",   32'(bus4.Q),   32'(CPR - 1));
        chk("unwrap_rev", 32'(bus4.REV), 32'd0);
        chk("unwrap_dir", 32'(bus4.DIR), 32'd0);
        check_state("unwrap");

        // x1: one full CW cycle from 00 gives exactly one count
        while (cur_ab != 2'b00)
            issue(gray(phase(cur_ab) + 1), 1'b1, 1'b0, 1'b0);
        base1 = steps1;
        for (int i = 0; i < 4; i++)
            issue(gray(phase(cur_ab) + 1), 1'b1, 1'b0, 1'b0);
        chk("x1_cycle_steps", 32'(steps1 - base1), 32'd1);
        check_state("x1_cycle");

        // illegal transition and ERR_CLR priority
        issue(2'b11, 1'b1, 1'b0, 1'b0);
        check_state("illegal");
        issue(2'b00, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("err_set_wins", 32'(bus4.ERR), 32'd1);
        issue(cur_ab, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("err_cleared", 32'(bus4.ERR), 32'd0);

        // PM low holds the count; re-enable must not count
        for (int i = 0; i < 5; i++)
            issue(gray(phase(cur_ab) + 1), 1'b0, 1'b0, 1'b0);
        check_state("pm_hold");
        issue(cur_ab, 1'b1, 1'b0, 1'b0);
        check_state("pm_reenable");

        // ZERO coinciding with a qualifying step
        issue(gray(phase(cur_ab) + 1), 1'b1, 1'b0, 1'b0);
        issue(gray(phase(cur_ab) + 1), 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("zero_step_q",   32'(bus4.Q),   32'd0);
        chk("zero_step_rev", 32'(bus4.REV), 32'd0);
        check_state("zero_step");

`ifdef QUAD_GLITCH_FILTER_EN
        // short pulse on A is swallowed; a held change counts with full latency
        @(negedge clk);
        bus4.OPTOA = ~cur_ab[1];
        repeat (2) @(negedge clk);
        bus4.OPTOA = cur_ab[1];
        repeat (15) @(negedge clk);
        check_state("glitch");
        lat_step("flt_lat");
`endif

        // randomized walk, including CCW underflow and a mid-rotation reset
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (i == 150) begin
                do_reset(gray(phase(cur_ab) + 1));
                check_state("mid_reset");
            end else if (r < 40)
                issue(gray(phase(cur_ab) + 1), 1'b1, 1'b0, ($urandom_range(0, 9) == 0));
            else if (r < 85)
                issue(gray(phase(cur_ab) - 1), 1'b1, 1'b0, ($urandom_range(0, 9) == 0));
            else if (r < 90)
                issue(gray(phase(cur_ab) + 2), 1'b1, 1'b0, 1'b0);
            else if (r < 96)
                issue(gray(phase(cur_ab) + 1), 1'b0, 1'b0, 1'b0);
            else if (r < 98)
                issue(cur_ab, 1'b1, 1'b0, 1'b1);
            else
                issue(gray(phase(cur_ab) - 1), 1'b1, 1'b1, 1'b0);
            if (i % 25 == 24) check_state("rand");
        end

        repeat (10) @(negedge clk);
        chk("pending4", 32'(q4.size()), 32'd0);
        chk("pending1", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
